dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between two requesters.
//  - Port 0: RISC-V core load/store unit.
//  - Port 1: loader/debug master, which preloads or inspects data memory.
//  Grants two-requester round-robin; one outstanding access; drives the memory's
//  address/read/write/data pins and returns read data to the granted port.
// PARAMETERS
//  ADDR_W  32  address width, both ports and memory side
//  DATA_W  32  data width
//  RD_LAT  1   cycles from mem_read strobe cycle to valid mem_rdata (1..7)
// PORTS
//  clk        in   1       system clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  p0_req     in   1       port0 request; held high until p0_gnt
//  p0_we      in   1       port0 1=write 0=read
//  p0_addr    in   ADDR_W  port0 address
//  p0_wdata   in   DATA_W  port0 write data
//  p0_gnt     out  1       port0 request accepted (1-cycle pulse)
//  p0_rvalid  out  1       port0 read data valid (1-cycle pulse)
//  p0_rdata   out  DATA_W  port0 read data
//  p1_*       -    -       identical set for port1
//  mem_addr   out  ADDR_W  to Data_memory Address
//  mem_write  out  1       to Data_memory write_data strobe
//  mem_read   out  1       to Data_memory read_data strobe
//  mem_wdata  out  DATA_W  to Data_memory Data_in
//  mem_rdata  in   DATA_W  from Data_memory Data_out
//  busy       out  1       high in any state other than IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0)
//  - All outputs 0; state=IDLE; last_gnt=1, so port0 wins the first tie.
//  - Any in-flight access is dropped; no rvalid is issued for it.
//  FSM
//  - IDLE: if any req, arbitrate this cycle (cycle T).
//    - Combinational pnX_gnt=1 for the winner only.
//    - Latch winner id, we, addr, wdata; go to ISSUE.
//  - ISSUE (T+1): mem_addr/mem_wdata = latched values.
//    - Write: mem_write=1 for exactly this cycle, then go to IDLE.
//    - Read: mem_read=1 for exactly this cycle, load cnt=RD_LAT, go to WAIT.
//  - WAIT: cnt decrements each cycle; mem_addr is held.
//    - When cnt reaches 0, capture mem_rdata into pX_rdata of the latched
//      winner, go to RESP.
//    - mem_rdata is captured at the end of cycle T+1+RD_LAT.
//  - RESP: pX_rvalid=1 for one cycle, go to IDLE.
//  - mem_addr and mem_wdata are 0 in IDLE.
//  Latency and throughput
//  - Write: gnt at T, mem_write at T+1, next grant possible at T+2.
//  - Read: gnt at T, rvalid at T+2+RD_LAT, next grant at T+3+RD_LAT.
//  Arbitration
//  - One req only: that port wins.
//  - Both req: the port != last_gnt wins; last_gnt updates on every grant.
//  - No grants outside IDLE; requests stay pending and are not lost.
//  Data and boundary rules
//  - pX_rdata holds its value until that port's next read completes;
//    the other port's traffic never alters it.
//  - Write data and address are latched at grant; changes after gnt are ignored.
//  - A req dropped before gnt is legal: no access occurs.
//  - Requester re-asserting in the cycle after gnt is treated as a new request.
//  - RD_LAT=0 is illegal (elaboration check).
//  - cnt is 3 bits and never wraps because of the RD_LAT<=7 bound.
// STRUCTURE
//  Shared header dmem_arb_defs.vh holds:
//  - State encodings IDLE/ISSUE/WAIT/RESP (2-bit).
//  - Port index localparams PORT_CORE=0 and PORT_DBG=1.
//  Sub-module rr_arbiter2:
//  - Inputs: req[1:0], last_gnt, enable. Output: gnt[1:0].
//  - Purely combinational; last_gnt register lives in dmem_arbiter.
// TESTING
//  1. Reset: rst_n=0 with reqs high.
//     -> gnt, rvalid, mem_* and busy all 0.
//     -> First grant after release goes to p0.
//  2. p0 write addr=0x10, data=0xDEADBEEF.
//     -> p0_gnt at T; mem_write=1 with mem_addr=0x10 at T+1.
//     -> busy=0 at T+2.
//  3. p1 read 0x10 after test 2, RD_LAT=1, memory model returns 0xDEADBEEF.
//     -> p1_rvalid at T+3 with p1_rdata=0xDEADBEEF; p0_rdata unchanged.
//  4. Both ports hold req for 4 accesses each.
//     -> Grants alternate p0,p1,p0,p1...; none lost; 8 memory strobes.
//  5. Reset asserted during WAIT of a p0 read.
//     -> No p0_rvalid; mem_read=0 immediately; clean IDLE after release.
//  6. RD_LAT=3 build, p0 read 0x20 returning 0x12345678.
//     -> rvalid exactly 5 cycles after gnt; p1 req during read granted at T+6.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// requester port indices and the wait-counter width.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam int PORT_CORE = 0;
    localparam int PORT_DBG  = 1;

    // Wide enough for read latencies up to 7 without wrapping.
    localparam int CNT_W = 3;

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter. Purely combinational; the caller owns
// the last-grant history register and enables arbitration only when idle.
module rr_arbiter2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       enable,
    output logic [1:0] gnt
);

    // A lone requester always wins; on a tie the port that was not granted last wins.
    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (req[PORT_CORE] && req[PORT_DBG]) begin
                gnt[PORT_CORE] = last_gnt;
                gnt[PORT_DBG]  = ~last_gnt;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the core LSU (port 0) and the
// loader/debug master (port 1). One access is outstanding at a time; reads
// return data to the port that was granted, after RD_LAT memory cycles.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic              mem_read,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    if (RD_LAT < 1 || RD_LAT > 7) begin : g_bad_rd_lat
        $error("dmem_arbiter: RD_LAT must be in 1..7");
    end

    localparam logic [CNT_W-1:0] RD_LAT_CNT = CNT_W'(RD_LAT);

    state_t              state;
    state_t              state_nxt;
    logic                last_gnt;
    logic [1:0]          gnt;
    logic                arb_en;
    logic                lat_port;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [CNT_W-1:0]    cnt;

    // Reset is folded into the enable so no grant pulse escapes while rst_n is low.
    assign arb_en = (state == S_IDLE) && rst_n;

    rr_arbiter2 u_rr (
        .req      ({p1_req, p0_req}),
        .last_gnt (last_gnt),
        .enable   (arb_en),
        .gnt      (gnt)
    );

    assign p0_gnt = gnt[PORT_CORE];
    assign p1_gnt = gnt[PORT_DBG];

    // State register plus grant bookkeeping: winner id, direction and tie-break history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            last_gnt <= 1'b1;
            lat_port <= 1'b0;
            lat_we   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (|gnt) begin
                last_gnt <= gnt[PORT_DBG];
                lat_port <= gnt[PORT_DBG];
                lat_we   <= gnt[PORT_DBG] ? p1_we : p0_we;
            end
        end
    end

    // Address and write data are captured at grant; later changes by the requester are ignored.
    always_ff @(posedge clk) begin
        if (|gnt) begin
            lat_addr  <= gnt[PORT_DBG] ? p1_addr  : p0_addr;
            lat_wdata <= gnt[PORT_DBG] ? p1_wdata : p0_wdata;
        end
    end

    // Read-latency counter: loaded on the read strobe, counts down through WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == S_ISSUE && !lat_we) begin
            cnt <= RD_LAT_CNT;
        end else if (state == S_WAIT) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Capture memory data on the last WAIT cycle into the granted port's holding register only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else if (state == S_WAIT && cnt == CNT_W'(1)) begin
            if (lat_port) begin
                p1_rdata <= mem_rdata;
            end else begin
                p0_rdata <= mem_rdata;
            end
        end
    end

    // Next-state and memory-side/response outputs; all strobes default low.
    always_comb begin
        state_nxt = state;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        p0_rvalid = 1'b0;
        p1_rvalid = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (|gnt) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_addr  = lat_addr;
                mem_wdata = lat_wdata;
                mem_write = lat_we;
                mem_read  = ~lat_we;
                state_nxt = lat_we ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                mem_addr = lat_addr;
                if (cnt == CNT_W'(1)) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                p0_rvalid = ~lat_port;
                p1_rvalid = lat_port;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              p0_req = 1'b0, p0_we = 1'b0;
    logic [ADDR_W-1:0] p0_addr = '0;
    logic [DATA_W-1:0] p0_wdata = '0;
    logic              p1_req = 1'b0, p1_we = 1'b0;
    logic [ADDR_W-1:0] p1_addr = '0;
    logic [DATA_W-1:0] p1_wdata = '0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [DATA_W-1:0] p0_rdata, p1_rdata, mem_wdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write, mem_read, busy;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_write(mem_write), .mem_read(mem_read),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Memory contents: unwritten locations return an address-derived pattern.
    logic [DATA_W-1:0] env_mem [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];

    function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
        return a ^ 32'hA5C3_0F00;
    endfunction

    // Transaction-level model state: when the arbiter is next free, the one
    // pending access, and what each port's read-data register should hold.
    int                free_cyc = 0;
    int                strobe_cyc = -1;
    int                rv_cyc = -1;
    int                last_port = 1;
    int                pport = 0;
    logic              pwe = 1'b0;
    logic [ADDR_W-1:0] paddr = '0;
    logic [DATA_W-1:0] pwdata = '0;
    logic [DATA_W-1:0] prdata = '0;
    logic [DATA_W-1:0] erd0 = '0, erd1 = '0;
    int                env_rd_cyc = -1;
    logic [DATA_W-1:0] env_rd_val = '0;

    always @(negedge clk) begin : compare
        logic idle, exp_w, exp_r;
        int   win;
        if (!rst_n) begin
            free_cyc = 0; strobe_cyc = -1; rv_cyc = -1; last_port = 1;
            erd0 = '0; erd1 = '0; env_rd_cyc = -1;
            check("reset_gnt", {p1_gnt, p0_gnt}, 0);
            check("reset_rvalid", {p1_rvalid, p0_rvalid}, 0);
            check("reset_strobes", {mem_write, mem_read, busy}, 0);
            check("reset_mem_addr", mem_addr, 0);
            check("reset_mem_wdata", mem_wdata, 0);
            check("reset_rdata", {p1_rdata, p0_rdata}, 0);
        end else begin
            idle = (cyc >= free_cyc);
            win = -1;
            if (idle && p0_req && p1_req) win = 1 - last_port;
            else if (idle && p0_req) win = 0;
            else if (idle && p1_req) win = 1;
            exp_w = (cyc == strobe_cyc) && pwe;
            exp_r = (cyc == strobe_cyc) && !pwe;
            if (cyc == rv_cyc) begin
                if (pport == 0) erd0 = prdata;
                else erd1 = prdata;
            end
            check("p0_gnt", p0_gnt, win == 0);
            check("p1_gnt", p1_gnt, win == 1);
            check("busy", busy, !idle);
            check("mem_write", mem_write, exp_w);
            check("mem_read", mem_read, exp_r);
            if (cyc == strobe_cyc) check("strobe_addr", mem_addr, paddr);
            if (exp_w) check("strobe_wdata", mem_wdata, pwdata);
            if (idle) begin
                check("idle_mem_addr", mem_addr, 0);
                check("idle_mem_wdata", mem_wdata, 0);
            end
            check("p0_rvalid", p0_rvalid, (cyc == rv_cyc) && pport == 0);
            check("p1_rvalid", p1_rvalid, (cyc == rv_cyc) && pport == 1);
            check("p0_rdata", p0_rdata, erd0);
            check("p1_rdata", p1_rdata, erd1);
            if (exp_w) ref_mem[paddr] = pwdata;
            if (win >= 0) begin
                last_port = win;
                pport = win;
                pwe = (win == 1) ? p1_we : p0_we;
                paddr = (win == 1) ? p1_addr : p0_addr;
                pwdata = (win == 1) ? p1_wdata : p0_wdata;
                strobe_cyc = cyc + 1;
                if (pwe) begin
                    free_cyc = cyc + 2;
                    rv_cyc = -1;
                end else begin
                    prdata = ref_mem.exists(paddr) ? ref_mem[paddr] : init_val(paddr);
                    free_cyc = cyc + 3 + RD_LAT;
                    rv_cyc = cyc + 2 + RD_LAT;
                end
            end
            // Memory environment driven from the DUT's own pins.
            if (mem_write) env_mem[mem_addr] = mem_wdata;
            if (mem_read) begin
                env_rd_cyc = cyc + RD_LAT;
                env_rd_val = env_mem.exists(mem_addr) ? env_mem[mem_addr] : init_val(mem_addr);
            end
        end
        mem_rdata <= (cyc == env_rd_cyc) ? env_rd_val : $urandom;
    end

    task automatic new_txn0();
        p0_req = 1'b1; p0_we = 1'($urandom_range(0, 1));
        p0_addr = ADDR_W'($urandom_range(0, 15) * 4); p0_wdata = $urandom;
    endtask

    task automatic new_txn1();
        p1_req = 1'b1; p1_we = 1'($urandom_range(0, 1));
        p1_addr = ADDR_W'($urandom_range(0, 15) * 4); p1_wdata = $urandom;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic g0, g1, got;
        int   n0, n1, strobes;
        int   seq[$];

        // Reset held with both ports requesting: p0 writes, p1 reads the same word.
        p0_req = 1; p0_we = 1; p0_addr = 32'h10; p0_wdata = 32'hDEADBEEF;
        p1_req = 1; p1_we = 0; p1_addr = 32'h10; p1_wdata = 32'h0;
        repeat (3) begin
            @(negedge clk);
            check("t1_rst_gnt", {p1_gnt, p0_gnt}, 2'b00);
            check("t1_rst_busy", busy, 0);
        end
        tick(); rst_n = 1;
        @(negedge clk);
        check("t1_first_gnt_p0", p0_gnt, 1);
        check("t1_first_gnt_p1", p1_gnt, 0);
        tick(); p0_req = 0; p0_addr = 32'hFFFF_FFF0; p0_wdata = 32'h0;
        @(negedge clk);
        check("t2_mem_write", mem_write, 1);
        check("t2_mem_addr", mem_addr, 32'h10);
        check("t2_mem_wdata", mem_wdata, 32'hDEADBEEF);
        check("t2_no_gnt_busy", p1_gnt, 0);
        tick();
        @(negedge clk);
        check("t2_busy_low", busy, 0);
        check("t3_p1_gnt", p1_gnt, 1);
        tick(); p1_req = 0;
        for (int k = 1; k <= RD_LAT + 1; k++) begin
            @(negedge clk);
            check("t3_rvalid_early", p1_rvalid, 0);
        end
        @(negedge clk);
        check("t3_p1_rvalid", p1_rvalid, 1);
        check("t3_p1_rdata", p1_rdata, 32'hDEADBEEF);
        check("t3_p0_rdata_kept", p0_rdata, 32'h0);
        tick();

        // Both ports hold requests for four accesses each.
        n0 = 0; n1 = 0; strobes = 0;
        new_txn0(); new_txn1();
        for (int i = 0; i < 200 && !(n0 == 4 && n1 == 4); i++) begin
            @(negedge clk);
            strobes += int'(mem_write) + int'(mem_read);
            g0 = p0_gnt; g1 = p1_gnt;
            if (g0) begin n0++; seq.push_back(0); end
            if (g1) begin n1++; seq.push_back(1); end
            tick();
            if (g0) begin if (n0 < 4) new_txn0(); else p0_req = 0; end
            if (g1) begin if (n1 < 4) new_txn1(); else p1_req = 0; end
        end
        repeat (RD_LAT + 4) begin
            @(negedge clk);
            strobes += int'(mem_write) + int'(mem_read);
        end
        check("t4_grants", seq.size(), 8);
        check("t4_strobes", strobes, 8);
        for (int i = 0; i < seq.size(); i++) check("t4_alternate", seq[i], i % 2);
        tick();

        // Reset lands while a p0 read is waiting for memory data.
        p0_req = 1; p0_we = 0; p0_addr = 32'h30;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (p0_gnt) got = 1; else tick();
        end
        check("t5_gnt", got, 1);
        tick(); p0_req = 0;
        @(negedge clk);
        check("t5_read_strobe", mem_read, 1);
        tick(); rst_n = 0;
        @(negedge clk);
        check("t5_rst_mem_read", mem_read, 0);
        check("t5_rst_busy", busy, 0);
        tick(); tick(); rst_n = 1;
        for (int k = 0; k < RD_LAT + 4; k++) begin
            @(negedge clk);
            check("t5_no_rvalid", p0_rvalid, 0);
            check("t5_idle", busy, 0);
        end
        tick();

        // Preload 0x20 via p1, then p0 reads it while p1 asks again mid-read.
        p1_req = 1; p1_we = 1; p1_addr = 32'h20; p1_wdata = 32'h12345678;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (p1_gnt) got = 1; else tick();
        end
        check("t6_preload_gnt", got, 1);
        tick(); p1_req = 0;
        tick();
        p0_req = 1; p0_we = 0; p0_addr = 32'h20;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (p0_gnt) got = 1; else tick();
        end
        check("t6_gnt", got, 1);
        tick(); p0_req = 0; p1_req = 1; p1_we = 1; p1_addr = 32'h24; p1_wdata = $urandom;
        for (int d = 1; d <= RD_LAT + 3; d++) begin
            @(negedge clk);
            check("t6_p0_rvalid", p0_rvalid, d == RD_LAT + 2);
            check("t6_p1_gnt", p1_gnt, d == RD_LAT + 3);
            if (d == RD_LAT + 2) check("t6_p0_rdata", p0_rdata, 32'h12345678);
        end
        tick(); p1_req = 0;

        // Randomized traffic with one mid-run reset.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            g0 = p0_gnt; g1 = p1_gnt;
            tick();
            if (i == 700) rst_n = 0;
            if (i == 702) rst_n = 1;
            if (g0) begin
                if ($urandom_range(0, 1) == 1) new_txn0(); else p0_req = 0;
            end else if (p0_req) begin
                if ($urandom_range(0, 19) == 0) p0_req = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                new_txn0();
            end
            if (g1) begin
                if ($urandom_range(0, 1) == 1) new_txn1(); else p1_req = 0;
            end else if (p1_req) begin
                if ($urandom_range(0, 19) == 0) p1_req = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                new_txn1();
            end
        end
        p0_req = 0; p1_req = 0;
        repeat (RD_LAT + 5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
